// File: rtl/alu_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer_if
// Bundles the three handshakes of the ALU command issuer:
//   cmd_*  : upstream command push (valid/ready, opcode, two operands)
//   alu_*  : issue strobe and operands to the ALU, registered result back
//   rsp_*  : response handshake (valid/ready, result, error) plus op_count
// Modports:
//   slave  : the issuer itself
//   master : the environment (command source, ALU, response sink)
// ---------------------------------------------------------------------------
interface alu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic [7:0]  op_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_start, alu_op, alu_a, alu_b,
               rsp_valid, rsp_result, rsp_err, op_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_start, alu_op, alu_a, alu_b,
               rsp_valid, rsp_result, rsp_err, op_count
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Queues ALU commands in a DEPTH-entry FIFO and issues them one at a time to
// an external ALU, capturing each result into a response register that is
// held until the downstream sink accepts it.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : alu_cmd_issuer_if.slave (command, ALU and response handshakes)
// Parameter:
//   DEPTH  : FIFO entries, power of two in 2..16
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    alu_cmd_issuer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    // FIFO entry layout: {op[2:0], a[7:0], b[7:0]}
    logic [18:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t      state_q, state_d;
    logic        alu_start_q, alu_start_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  op_count_q, op_count_d;

    logic        cmd_ready;
    logic        push;
    logic        pop;
    logic [18:0] head;

    // Ready depends on the registered count only, so a full FIFO that pops
    // this cycle still refuses a push until the next cycle.
    assign cmd_ready = (count_q < DEPTH_C);
    assign push      = bus.cmd_valid && cmd_ready;
    // The head is consumed at the end of the single ISSUE cycle.
    assign pop       = (state_q == ISSUE);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        alu_start_d  = 1'b0;
        alu_op_d     = 3'd0;
        alu_a_d      = 8'd0;
        alu_b_d      = 8'd0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Outputs are registered: the values loaded on a transition are the
        // ones seen while sitting in the destination state.
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d     = ISSUE;
                    alu_start_d = 1'b1;
                    alu_op_d    = head[18:16];
                    alu_a_d     = head[15:8];
                    alu_b_d     = head[7:0];
                end
            end
            ISSUE: begin
                state_d = CAPT;
            end
            CAPT: begin
                // ALU outputs are valid here, one cycle after the start strobe.
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_result_d = bus.alu_result;
                rsp_err_d    = ~bus.alu_done;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            alu_start_q  <= 1'b0;
            alu_op_q     <= 3'd0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'd0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            alu_start_q  <= alu_start_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.alu_start  = alu_start_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
// Directed bench for alu_cmd_issuer (DEPTH=4) with a small stand-in ALU that
// registers its result one cycle after alu_start, keeps its previous result
// for NOP and unsupported opcodes, and withholds alu_done for opcodes 5-7.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer_if bus();

    alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in ALU
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.alu_done   <= 1'b0;
            bus.alu_result <= 16'd0;
        end else begin
            bus.alu_done <= 1'b0;
            if (bus.alu_start) begin
                case (bus.alu_op)
                    3'd0: bus.alu_done <= 1'b1;
                    3'd1: begin
                        bus.alu_result <= {8'd0, bus.alu_a} + {8'd0, bus.alu_b};
                        bus.alu_done   <= 1'b1;
                    end
                    3'd2: begin
                        bus.alu_result <= {8'd0, bus.alu_a & bus.alu_b};
                        bus.alu_done   <= 1'b1;
                    end
                    3'd3: begin
                        bus.alu_result <= {8'd0, bus.alu_a ^ bus.alu_b};
                        bus.alu_done   <= 1'b1;
                    end
                    3'd4: begin
                        bus.alu_result <= 16'(bus.alu_a) * 16'(bus.alu_b);
                        bus.alu_done   <= 1'b1;
                    end
                    default: bus.alu_done <= 1'b0;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command; returns whether an edge accepted it within budget.
    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int budget, output bit accepted);
        accepted      = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int n = 0; n < budget && !accepted; n++) begin
            if (bus.cmd_ready) accepted = 1'b1;
            step();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_ok(input string tag, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        bit acc;
        push(op, a, b, 30, acc);
        check({tag, "_accept"}, 32'(acc), 32'd1);
    endtask

    // Waits for a response, checks it, then spends one edge (consumed if rsp_ready=1).
    task automatic get_rsp(input string tag, input logic [15:0] exp_res, input logic exp_err);
        bit seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            if (bus.rsp_valid) seen = 1'b1;
            else step();
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_result"}, 32'(bus.rsp_result), 32'(exp_res));
            check({tag, "_err"},    32'(bus.rsp_err),    32'(exp_err));
            step();
        end
    endtask

    initial begin
        bit acc;
        bit seen;

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.rsp_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
        check("rst_alu_start",  32'(bus.alu_start),  32'd0);
        check("rst_alu_op",     32'(bus.alu_op),     32'd0);
        check("rst_alu_a",      32'(bus.alu_a),      32'd0);
        check("rst_alu_b",      32'(bus.alu_b),      32'd0);
        check("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
        check("rst_op_count",   32'(bus.op_count),   32'd0);
        reset = 1'b0;

        // Single Add FF+01, cycle-exact latency
        bus.rsp_ready = 1'b1;
        push_ok("add1", 3'd1, 8'hFF, 8'h01);
        check("lat_e0_start",   32'(bus.alu_start),  32'd0);
        step();
        check("lat_e1_start",   32'(bus.alu_start),  32'd1);
        check("lat_e1_op",      32'(bus.alu_op),     32'd1);
        check("lat_e1_a",       32'(bus.alu_a),      32'hFF);
        check("lat_e1_b",       32'(bus.alu_b),      32'h01);
        step();
        check("lat_e2_start",   32'(bus.alu_start),  32'd0);
        check("lat_e2_op",      32'(bus.alu_op),     32'd0);
        check("lat_e2_rvalid",  32'(bus.rsp_valid),  32'd0);
        step();
        check("lat_e3_rvalid",  32'(bus.rsp_valid),  32'd1);
        check("lat_e3_result",  32'(bus.rsp_result), 32'h0100);
        check("lat_e3_err",     32'(bus.rsp_err),    32'd0);
        step();
        check("lat_e4_rvalid",  32'(bus.rsp_valid),  32'd0);
        check("lat_e4_count",   32'(bus.op_count),   32'd1);

        // Mul then XOR back-to-back
        bus.rsp_ready = 1'b0;
        push_ok("mul", 3'd4, 8'hFF, 8'hFF);
        push_ok("xor", 3'd3, 8'hF0, 8'h3C);
        bus.rsp_ready = 1'b1;
        get_rsp("mul_rsp", 16'hFE01, 1'b0);
        get_rsp("xor_rsp", 16'h00CC, 1'b0);
        check("count_after_mulxor", 32'(bus.op_count), 32'd3);

        // Unsupported ops, NOP and And
        bus.rsp_ready = 1'b0;
        push_ok("add23", 3'd1, 8'h02, 8'h03);
        push_ok("op6",   3'd6, 8'h11, 8'h22);
        push_ok("and",   3'd2, 8'h0F, 8'hFF);
        push_ok("nop",   3'd0, 8'h55, 8'h66);
        push_ok("op7",   3'd7, 8'h01, 8'h01);
        bus.rsp_ready = 1'b1;
        get_rsp("add23_rsp", 16'h0005, 1'b0);
        get_rsp("op6_rsp",   16'h0005, 1'b1);
        get_rsp("and_rsp",   16'h000F, 1'b0);
        get_rsp("nop_rsp",   16'h000F, 1'b0);
        get_rsp("op7_rsp",   16'h000F, 1'b1);
        check("count_after_mix", 32'(bus.op_count), 32'd8);

        // Backpressure: 4 queued plus 1 in flight, then the next push stalls
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_ok("bp_push", 3'd1, 8'(10 + i), 8'h01);
        end
        check("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
        push(3'd1, 8'h40, 8'h01, 6, acc);
        check("bp_stall", 32'(acc), 32'd0);
        check("bp_hold_valid",  32'(bus.rsp_valid),  32'd1);
        check("bp_hold_result", 32'(bus.rsp_result), 32'h000B);
        bus.rsp_ready = 1'b1;
        get_rsp("bp_rsp0", 16'h000B, 1'b0);
        get_rsp("bp_rsp1", 16'h000C, 1'b0);
        get_rsp("bp_rsp2", 16'h000D, 1'b0);
        get_rsp("bp_rsp3", 16'h000E, 1'b0);
        get_rsp("bp_rsp4", 16'h000F, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (bus.rsp_valid) seen = 1'b1;
            step();
        end
        check("bp_no_extra_rsp", 32'(seen), 32'd0);
        check("bp_count",        32'(bus.op_count), 32'd13);

        // Reset during CAPT with two commands queued
        bus.rsp_ready = 1'b0;
        push_ok("rc_push0", 3'd1, 8'h01, 8'h02);
        push_ok("rc_push1", 3'd1, 8'h03, 8'h04);
        push_ok("rc_push2", 3'd1, 8'h05, 8'h06);
        reset = 1'b1;
        #1;
        check("rc_cmd_ready",  32'(bus.cmd_ready),  32'd1);
        check("rc_alu_start",  32'(bus.alu_start),  32'd0);
        check("rc_alu_op",     32'(bus.alu_op),     32'd0);
        check("rc_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("rc_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("rc_rsp_err",    32'(bus.rsp_err),    32'd0);
        check("rc_op_count",   32'(bus.op_count),   32'd0);
        step();
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        seen          = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus.rsp_valid || bus.alu_start) seen = 1'b1;
            step();
        end
        check("rc_no_rsp_after_release", 32'(seen), 32'd0);
        push_ok("rc_new", 3'd1, 8'h01, 8'h01);
        get_rsp("rc_new_rsp", 16'h0002, 1'b0);
        check("rc_count", 32'(bus.op_count), 32'd1);

        // op_count wrap at 256 completions
        for (int i = 0; i < 254; i++) begin
            push_ok("wrap_push", 3'd0, 8'h00, 8'h00);
            get_rsp("wrap_rsp", 16'h0002, 1'b0);
        end
        check("wrap_count_255", 32'(bus.op_count), 32'd255);
        push_ok("wrap_last", 3'd0, 8'h00, 8'h00);
        get_rsp("wrap_last_rsp", 16'h0002, 1'b0);
        check("wrap_count_0", 32'(bus.op_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  FIFO can accept a command.
REQ-006 cmd_op  input  3  ALU opcode (0 NOP, 1 Add, 2 And, 3 XOR, 4 Mul, 5-7 unsupported).
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 alu_start  output  1  start strobe to ALU.
REQ-009 alu_op  output  3;  alu_a, alu_b  output  8 each;  head-of-FIFO command to ALU.
REQ-010 alu_done  input  1;  alu_result  input  16;  registered ALU outputs, valid one cycle after alu_start.
REQ-011 rsp_valid  output  1;  rsp_ready  input  1;  response handshake.
REQ-012 rsp_result  output  16;  rsp_err  output  1;  captured result, error flag.
REQ-013 op_count  output  8  completed responses, modulo 256.

Function
REQ-014 Command transfer SHALL occur on a rising edge with cmd_valid=1 and cmd_ready=1; entry {op,a,b} written at FIFO tail.
REQ-015 cmd_ready SHALL equal (count < DEPTH), derived from registered count only, independent of cmd_valid.
REQ-016 Push and pop in the same cycle SHALL leave count unchanged, including when full (pop frees slot; push accepted only if cmd_ready was 1).
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPT, RESP.
REQ-018 IDLE: if FIFO non-empty, next state ISSUE; else stay IDLE.
REQ-019 ISSUE (exactly one cycle): alu_start=1, alu_op/alu_a/alu_b = FIFO head; FIFO head popped at end of cycle; next state CAPT.
REQ-020 CAPT (exactly one cycle): at end of cycle rsp_result <= alu_result, rsp_err <= ~alu_done; next state RESP.
REQ-021 RESP: rsp_valid=1; rsp_result/rsp_err held stable; on rsp_ready=1 -> op_count increments (wraps 255->0), next state IDLE.
REQ-022 rsp_valid SHALL be 1 only in RESP; alu_start SHALL be 1 only in ISSUE; alu_op/a/b SHALL be 0 outside ISSUE.
REQ-023 Minimum latency: command accepted at edge E0 into empty FIFO with FSM IDLE -> ISSUE after E1, CAPT after E2, rsp_valid=1 after E3.
REQ-024 Throughput: one command per 4 cycles maximum (IDLE visited between responses).
REQ-025 Backpressure: rsp_ready=0 SHALL hold RESP indefinitely; FIFO SHALL keep accepting until full.
REQ-026 Unsupported opcode (5-7) SHALL be forwarded unchanged; resulting rsp_err=1 with rsp_result = ALU's held result.
REQ-027 NOP SHALL be issued like any op; rsp_result = ALU's previous result, rsp_err=0.
REQ-028 Responses SHALL be returned in command order; no command dropped or duplicated.

Reset
REQ-029 reset=1 SHALL immediately force: FSM IDLE, FIFO empty, cmd_ready=1, alu_start=0, alu_op/a/b=0, rsp_valid=0, rsp_result=0, rsp_err=0, op_count=0.
REQ-030 Reset asserted mid-operation (any state) SHALL discard in-flight and queued commands; no response emitted for them after release.
REQ-031 First command accepted SHALL be the first on the rising edge after reset deasserts.

Verification
REQ-032 Single Add a=8'hFF b=8'h01, rsp_ready=1 -> alu_start one cycle, rsp_valid 3 edges after accept, rsp_result=16'h0100, rsp_err=0, op_count=1.
REQ-033 Mul a=8'hFF b=8'hFF then XOR a=8'hF0 b=8'h3C back-to-back -> responses in order 16'hFE01 then 16'h00CC, both rsp_err=0.
REQ-034 rsp_ready=0, push DEPTH+1 commands -> cmd_ready=0 after 4 queued plus 1 in flight... push stalls; release rsp_ready -> all responses in order, none lost.
REQ-035 op=3'b110 after Add 2+3 -> rsp_err=1, rsp_result=16'h0005; following And 8'h0F&8'hFF -> 16'h000F, rsp_err=0.
REQ-036 Assert reset during CAPT with 2 queued commands -> all outputs at reset values same cycle; no rsp_valid after release until new command.
REQ-037 256 completed responses -> op_count wraps to 0.
